riscv_tag_check_ctrl: RTL and testbench
=======================================

Name: riscv_tag_check_ctrl

Overview:
Sequences the DIFT tag-check policy between the CSR file, the check decoder and the EX stage.
- Owns the active Tag Check Register (TCR) and feeds it to the check decoder.
- Combines the per-operand check enables with the operand tags to detect policy violations.
- On a violation: kills the faulting writeback, stalls the pipeline, captures fault context and holds a trap request to the controller until acknowledged.
- Counts violations and defers CSR writes to the TCR until the pipeline is idle.

Parameters:
CNT_WIDTH, 16, width of the saturating violation counter
TCR_RST, 32'h0000_0000, value loaded into the TCR on reset

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
ex_valid_i  in  1  instruction in EX retires this cycle
ex_pc_i  in  32  PC of the EX instruction
ex_instr_i  in  32  encoding of the EX instruction
chk_s1_i / chk_s2_i / chk_d_i  in  1 each  check enables from the check decoder
tag_s1_i / tag_s2_i / tag_d_i  in  1 each  tags of rs1, rs2/store data and destination/address operand
tcr_wr_i  in  1  CSR write strobe for the TCR
tcr_wdata_i  in  32  CSR write data
tcr_o  out  32  active TCR, to the check decoder
kill_wb_o  out  1  suppress register/memory writeback of the EX instruction (combinational)
halt_ex_o  out  1  stall IF/ID/EX
trap_req_o  out  1  security-exception request to the controller
trap_ack_i  in  1  controller accepted the trap
trap_cause_o  out  4  {pc, d, s2, s1} violation bitmask
fault_pc_o  out  32  captured PC of the faulting instruction
fault_instr_o  out  32  captured encoding of the faulting instruction
clr_cnt_i  in  1  clear the violation counter
viol_cnt_o  out  CNT_WIDTH  saturating violation count

Behaviour:
- Violation term: viol = ex_valid_i & state==IDLE & |cause.
  - cause[0] = chk_s1_i & tag_s1_i
  - cause[1] = chk_s2_i & tag_s2_i
  - cause[2] = chk_d_i & tag_d_i
  - cause[3] = 0 unless the optional feature is enabled.
- kill_wb_o = viol, same cycle, combinational.
- Reset values: tcr_o = TCR_RST; trap_req_o = 0; trap_cause_o = 0; fault_pc_o = 0; fault_instr_o = 0; viol_cnt_o = 0; state = IDLE; pending TCR write cleared.
- FSM states IDLE, REQ, DRAIN:
  - IDLE: on viol, register ex_pc_i, ex_instr_i and cause into the fault outputs; next state REQ.
  - REQ: trap_req_o = 1 (registered, first high one cycle after detection). Stay in REQ until trap_ack_i = 1, then go to DRAIN.
  - DRAIN: one cycle for the controller redirect to take effect, then IDLE.
- halt_ex_o = (state != IDLE). It is low in the detect cycle; kill_wb_o covers that cycle.
- ex_valid_i and tag inputs are ignored outside IDLE.
- trap_ack_i is ignored outside REQ.
- Fault outputs hold their last captured value until the next violation.
- TCR writes:
  - In IDLE with no viol: tcr_o = tcr_wdata_i on the next cycle.
  - In the same cycle as viol, or outside IDLE: the write goes into a pending register; the last write wins.
  - Pending data is applied on the DRAIN->IDLE transition, so tcr_o changes in the first IDLE cycle.
  - The check in progress always uses the old TCR.
- Counter:
  - Increments on viol and saturates at all ones; there is no wrap.
  - clr_cnt_i alone clears it to 0.
  - clr_cnt_i together with viol gives 1.
- Reset asserted in any state returns to IDLE next cycle and discards the pending TCR write. trap_req_o drops with no ack required.

Optional Feature:
TAG_CHECK_EXEC_PC_EN
- Enabled:
  - Adds input pc_tag_i (1): the tag of the fetched PC.
  - cause[3] = ex_valid_i & tcr_o[EXECUTE_PC] & pc_tag_i, with EXECUTE_PC from riscv_defines.
  - cause[3] participates in viol, kill_wb_o, capture and counting exactly like the other bits.
- Disabled: port pc_tag_i absent; cause[3] tied to 0. trap_cause_o stays 4 bits wide in both builds.

Test Plan:
1. TCR_RST=0, tcr_wr_i=1 with wdata=32'h0000_0007 in IDLE -> tcr_o=32'h7 the next cycle; no trap.
2. ex_valid_i=1, chk_s1_i=1, tag_s1_i=1, ex_pc_i=32'h80 -> detect cycle: kill_wb_o=1. Next cycle: trap_req_o=1, trap_cause_o=4'b0001, fault_pc_o=32'h80, halt_ex_o=1, viol_cnt_o=1. Hold ack low for 5 cycles -> trap_req_o stays 1. Ack -> one DRAIN cycle, then halt_ex_o=0.
3. Violation with chk_s2_i=1 while tag_s2_i=0 and chk_d_i=tag_d_i=1 -> trap_cause_o=4'b0100.
4. tcr_wr_i in REQ with 32'hA, then 32'hB in DRAIN -> tcr_o unchanged until the first IDLE cycle, then 32'hB.
5. CNT_WIDTH=2, drive 4 violations -> viol_cnt_o saturates at 3. clr_cnt_i together with a viol -> 1.
6. rst_n=0 for one cycle while in REQ -> next cycle: trap_req_o=0, halt_ex_o=0, tcr_o=TCR_RST, viol_cnt_o=0.

Source files
------------

// File: rtl/riscv_tag_check_ctrl.sv
// DIFT tag-check sequencer: owns the TCR, flags tag-policy violations, raises a held trap request and counts violations.
// Optional build macro TAG_CHECK_EXEC_PC_EN adds pc_tag_i and the execute-PC cause bit.
module riscv_tag_check_ctrl #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter logic [31:0] TCR_RST   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid_i,
    input  logic [31:0]          ex_pc_i,
    input  logic [31:0]          ex_instr_i,
    input  logic                 chk_s1_i,
    input  logic                 chk_s2_i,
    input  logic                 chk_d_i,
    input  logic                 tag_s1_i,
    input  logic                 tag_s2_i,
    input  logic                 tag_d_i,
`ifdef TAG_CHECK_EXEC_PC_EN
    input  logic                 pc_tag_i,
`endif
    input  logic                 tcr_wr_i,
    input  logic [31:0]          tcr_wdata_i,
    output logic [31:0]          tcr_o,
    output logic                 kill_wb_o,
    output logic                 halt_ex_o,
    output logic                 trap_req_o,
    input  logic                 trap_ack_i,
    output logic [3:0]           trap_cause_o,
    output logic [31:0]          fault_pc_o,
    output logic [31:0]          fault_instr_o,
    input  logic                 clr_cnt_i,
    output logic [CNT_WIDTH-1:0] viol_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_r, state_next_s;
    logic [3:0]             cause_s, cause_r;
    logic                   viol_s;
    logic [31:0]            tcr_r, tcr_next_s;
    logic                   pend_valid_r, pend_valid_next_s;
    logic [31:0]            pend_data_r, pend_data_next_s;
    logic [31:0]            fault_pc_r, fault_instr_r;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_next_s;

    // Per-operand policy violation bits
    always_comb begin
        cause_s    = 4'b0000;
        cause_s[0] = chk_s1_i & tag_s1_i;
        cause_s[1] = chk_s2_i & tag_s2_i;
        cause_s[2] = chk_d_i & tag_d_i;
`ifdef TAG_CHECK_EXEC_PC_EN
        cause_s[3] = ex_valid_i & tcr_r[riscv_defines::EXECUTE_PC] & pc_tag_i;
`else
        cause_s[3] = 1'b0;
`endif
    end

    assign viol_s       = ex_valid_i & (state_r == ST_IDLE) & (|cause_s);
    assign kill_wb_o    = viol_s;
    assign halt_ex_o    = (state_r != ST_IDLE);
    assign trap_req_o   = (state_r == ST_REQ);
    assign tcr_o        = tcr_r;
    assign trap_cause_o = cause_r;
    assign fault_pc_o   = fault_pc_r;
    assign fault_instr_o = fault_instr_r;
    assign viol_cnt_o   = cnt_r;

    // Trap sequencing next state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  if (viol_s) state_next_s = ST_REQ; else state_next_s = ST_IDLE;
            ST_REQ:   if (trap_ack_i) state_next_s = ST_DRAIN; else state_next_s = ST_REQ;
            ST_DRAIN: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // TCR update: immediate when idle and clean, otherwise parked until the drain cycle ends
    always_comb begin
        tcr_next_s        = tcr_r;
        pend_valid_next_s = pend_valid_r;
        pend_data_next_s  = pend_data_r;
        case (state_r)
            ST_IDLE: begin
                if (tcr_wr_i && !viol_s) begin
                    tcr_next_s = tcr_wdata_i;
                end else if (tcr_wr_i) begin
                    pend_valid_next_s = 1'b1;
                    pend_data_next_s  = tcr_wdata_i;
                end else begin
                    tcr_next_s = tcr_r;
                end
            end
            ST_REQ: begin
                if (tcr_wr_i) begin
                    pend_valid_next_s = 1'b1;
                    pend_data_next_s  = tcr_wdata_i;
                end else begin
                    pend_valid_next_s = pend_valid_r;
                end
            end
            ST_DRAIN: begin
                pend_valid_next_s = 1'b0;
                if (tcr_wr_i) begin
                    tcr_next_s = tcr_wdata_i;
                end else if (pend_valid_r) begin
                    tcr_next_s = pend_data_r;
                end else begin
                    tcr_next_s = tcr_r;
                end
            end
            default: begin
                pend_valid_next_s = 1'b0;
            end
        endcase
    end

    // Saturating violation counter; a clear coinciding with a violation counts that violation
    always_comb begin
        cnt_next_s = cnt_r;
        if (clr_cnt_i && viol_s) begin
            cnt_next_s = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else if (clr_cnt_i) begin
            cnt_next_s = {CNT_WIDTH{1'b0}};
        end else if (viol_s && !(&cnt_r)) begin
            cnt_next_s = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // State, TCR, counter and fault-context registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            tcr_r         <= TCR_RST;
            pend_valid_r  <= 1'b0;
            pend_data_r   <= 32'h0000_0000;
            cause_r       <= 4'b0000;
            fault_pc_r    <= 32'h0000_0000;
            fault_instr_r <= 32'h0000_0000;
            cnt_r         <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r      <= state_next_s;
            tcr_r        <= tcr_next_s;
            pend_valid_r <= pend_valid_next_s;
            pend_data_r  <= pend_data_next_s;
            cnt_r        <= cnt_next_s;
            if (viol_s) begin
                cause_r       <= cause_s;
                fault_pc_r    <= ex_pc_i;
                fault_instr_r <= ex_instr_i;
            end else begin
                cause_r       <= cause_r;
                fault_pc_r    <= fault_pc_r;
                fault_instr_r <= fault_instr_r;
            end
        end
    end

endmodule

// File: tb/tb_riscv_tag_check_ctrl.sv
// Directed self-checking bench for riscv_tag_check_ctrl (CNT_WIDTH=2 so saturation is reachable).
module tb_riscv_tag_check_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i;
    logic [31:0] ex_pc_i, ex_instr_i;
    logic        chk_s1_i, chk_s2_i, chk_d_i;
    logic        tag_s1_i, tag_s2_i, tag_d_i;
    logic        pc_tag_i;
    logic        tcr_wr_i;
    logic [31:0] tcr_wdata_i;
    logic [31:0] tcr_o;
    logic        kill_wb_o, halt_ex_o, trap_req_o;
    logic        trap_ack_i;
    logic [3:0]  trap_cause_o;
    logic [31:0] fault_pc_o, fault_instr_o;
    logic        clr_cnt_i;
    logic [1:0]  viol_cnt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_tag_check_ctrl #(.CNT_WIDTH(2), .TCR_RST(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_instr_i(ex_instr_i),
        .chk_s1_i(chk_s1_i), .chk_s2_i(chk_s2_i), .chk_d_i(chk_d_i),
        .tag_s1_i(tag_s1_i), .tag_s2_i(tag_s2_i), .tag_d_i(tag_d_i),
`ifdef TAG_CHECK_EXEC_PC_EN
        .pc_tag_i(pc_tag_i),
`endif
        .tcr_wr_i(tcr_wr_i), .tcr_wdata_i(tcr_wdata_i), .tcr_o(tcr_o),
        .kill_wb_o(kill_wb_o), .halt_ex_o(halt_ex_o), .trap_req_o(trap_req_o),
        .trap_ack_i(trap_ack_i), .trap_cause_o(trap_cause_o),
        .fault_pc_o(fault_pc_o), .fault_instr_o(fault_instr_o),
        .clr_cnt_i(clr_cnt_i), .viol_cnt_o(viol_cnt_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid_i = 1'b0; ex_pc_i = 32'h0; ex_instr_i = 32'h0;
        chk_s1_i = 1'b0; chk_s2_i = 1'b0; chk_d_i = 1'b0;
        tag_s1_i = 1'b0; tag_s2_i = 1'b0; tag_d_i = 1'b0;
        pc_tag_i = 1'b0; tcr_wr_i = 1'b0; tcr_wdata_i = 32'h0;
        trap_ack_i = 1'b0; clr_cnt_i = 1'b0;
    endtask

    // Present an rs1 violation for one detect cycle and advance into REQ
    task automatic raise_s1_viol(input logic [31:0] pc, input logic [31:0] instr);
        ex_valid_i = 1'b1; chk_s1_i = 1'b1; tag_s1_i = 1'b1;
        ex_pc_i = pc; ex_instr_i = instr;
        step();
        idle_inputs();
    endtask

    task automatic ack_and_drain();
        trap_ack_i = 1'b1;
        step();
        trap_ack_i = 1'b0;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        checks++; if (tcr_o !== 32'h0) begin failures++; $display("FAIL reset_tcr got=%h exp=%h", tcr_o, 32'h0); end
        checks++; if (trap_req_o !== 1'b0) begin failures++; $display("FAIL reset_trap_req got=%b exp=0", trap_req_o); end
        checks++; if (halt_ex_o !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", halt_ex_o); end
        checks++; if (trap_cause_o !== 4'b0000) begin failures++; $display("FAIL reset_cause got=%b exp=0000", trap_cause_o); end
        checks++; if (fault_pc_o !== 32'h0 || fault_instr_o !== 32'h0) begin failures++; $display("FAIL reset_fault got=%h/%h exp=0/0", fault_pc_o, fault_instr_o); end
        checks++; if (viol_cnt_o !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", viol_cnt_o); end
    endtask

    task automatic test_tcr_write();
        tcr_wr_i = 1'b1; tcr_wdata_i = 32'h0000_0007;
        #1;
        checks++; if (tcr_o !== 32'h0) begin failures++; $display("FAIL tcr_write_early got=%h exp=0", tcr_o); end
        step();
        idle_inputs();
        checks++; if (tcr_o !== 32'h7) begin failures++; $display("FAIL tcr_write got=%h exp=%h", tcr_o, 32'h7); end
        checks++; if (trap_req_o !== 1'b0 || halt_ex_o !== 1'b0) begin failures++; $display("FAIL tcr_write_notrap got=%b%b exp=00", trap_req_o, halt_ex_o); end
    endtask

    task automatic test_violation();
        ex_valid_i = 1'b1; chk_s1_i = 1'b1; tag_s1_i = 1'b1;
        ex_pc_i = 32'h0000_0080; ex_instr_i = 32'h0010_0093;
        #1;
        checks++; if (kill_wb_o !== 1'b1) begin failures++; $display("FAIL detect_kill got=%b exp=1", kill_wb_o); end
        checks++; if (halt_ex_o !== 1'b0 || trap_req_o !== 1'b0) begin failures++; $display("FAIL detect_nohalt got=%b%b exp=00", halt_ex_o, trap_req_o); end
        step();
        idle_inputs();
        checks++; if (trap_req_o !== 1'b1) begin failures++; $display("FAIL req_high got=%b exp=1", trap_req_o); end
        checks++; if (trap_cause_o !== 4'b0001) begin failures++; $display("FAIL cause_s1 got=%b exp=0001", trap_cause_o); end
        checks++; if (fault_pc_o !== 32'h80) begin failures++; $display("FAIL fault_pc got=%h exp=%h", fault_pc_o, 32'h80); end
        checks++; if (fault_instr_o !== 32'h0010_0093) begin failures++; $display("FAIL fault_instr got=%h exp=%h", fault_instr_o, 32'h0010_0093); end
        checks++; if (halt_ex_o !== 1'b1) begin failures++; $display("FAIL req_halt got=%b exp=1", halt_ex_o); end
        checks++; if (viol_cnt_o !== 2'd1) begin failures++; $display("FAIL cnt_one got=%0d exp=1", viol_cnt_o); end
        // Another tagged instruction during REQ must be ignored
        ex_valid_i = 1'b1; chk_d_i = 1'b1; tag_d_i = 1'b1; ex_pc_i = 32'h0000_0444;
        #1;
        checks++; if (kill_wb_o !== 1'b0) begin failures++; $display("FAIL req_ignore_kill got=%b exp=0", kill_wb_o); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (trap_req_o !== 1'b1) begin failures++; $display("FAIL req_hold[%0d] got=%b exp=1", i, trap_req_o); end
        end
        idle_inputs();
        checks++; if (fault_pc_o !== 32'h80 || viol_cnt_o !== 2'd1) begin failures++; $display("FAIL req_ignore_ctx got=%h/%0d exp=80/1", fault_pc_o, viol_cnt_o); end
        trap_ack_i = 1'b1;
        step();
        trap_ack_i = 1'b0;
        checks++; if (trap_req_o !== 1'b0 || halt_ex_o !== 1'b1) begin failures++; $display("FAIL drain got=%b%b exp=01", trap_req_o, halt_ex_o); end
        step();
        checks++; if (halt_ex_o !== 1'b0) begin failures++; $display("FAIL drain_done got=%b exp=0", halt_ex_o); end
        checks++; if (fault_pc_o !== 32'h80) begin failures++; $display("FAIL fault_hold got=%h exp=%h", fault_pc_o, 32'h80); end
    endtask

    task automatic test_cause_mask();
        // check enable without tag, and tag without valid: no violation
        ex_valid_i = 1'b1; chk_s1_i = 1'b0; tag_s1_i = 1'b1;
        #1;
        checks++; if (kill_wb_o !== 1'b0) begin failures++; $display("FAIL nochk_kill got=%b exp=0", kill_wb_o); end
        ex_valid_i = 1'b0; chk_s1_i = 1'b1;
        #1;
        checks++; if (kill_wb_o !== 1'b0) begin failures++; $display("FAIL novalid_kill got=%b exp=0", kill_wb_o); end
        idle_inputs();
        ex_valid_i = 1'b1; chk_s2_i = 1'b1; tag_s2_i = 1'b0; chk_d_i = 1'b1; tag_d_i = 1'b1;
        ex_pc_i = 32'h0000_0100; ex_instr_i = 32'h00B5_2023;
        #1;
        checks++; if (kill_wb_o !== 1'b1) begin failures++; $display("FAIL d_kill got=%b exp=1", kill_wb_o); end
        step();
        idle_inputs();
        checks++; if (trap_cause_o !== 4'b0100) begin failures++; $display("FAIL cause_d got=%b exp=0100", trap_cause_o); end
        checks++; if (fault_pc_o !== 32'h100) begin failures++; $display("FAIL fault_pc2 got=%h exp=%h", fault_pc_o, 32'h100); end
        checks++; if (viol_cnt_o !== 2'd2) begin failures++; $display("FAIL cnt_two got=%0d exp=2", viol_cnt_o); end
        ack_and_drain();
    endtask

    task automatic test_deferred_tcr();
        raise_s1_viol(32'h0000_0200, 32'h0000_0013);
        checks++; if (viol_cnt_o !== 2'd3) begin failures++; $display("FAIL cnt_three got=%0d exp=3", viol_cnt_o); end
        tcr_wr_i = 1'b1; tcr_wdata_i = 32'h0000_000A;
        step();
        tcr_wr_i = 1'b0;
        checks++; if (tcr_o !== 32'h7) begin failures++; $display("FAIL defer_req got=%h exp=%h", tcr_o, 32'h7); end
        trap_ack_i = 1'b1;
        step();
        trap_ack_i = 1'b0;
        checks++; if (tcr_o !== 32'h7) begin failures++; $display("FAIL defer_drain got=%h exp=%h", tcr_o, 32'h7); end
        tcr_wr_i = 1'b1; tcr_wdata_i = 32'h0000_000B;
        step();
        idle_inputs();
        checks++; if (tcr_o !== 32'hB || halt_ex_o !== 1'b0) begin failures++; $display("FAIL defer_apply got=%h/%b exp=b/0", tcr_o, halt_ex_o); end
    endtask

    task automatic test_saturation();
        // TCR write coincident with a violation is deferred
        ex_valid_i = 1'b1; chk_s1_i = 1'b1; tag_s1_i = 1'b1; ex_pc_i = 32'h0000_0300;
        tcr_wr_i = 1'b1; tcr_wdata_i = 32'h0000_000C;
        step();
        idle_inputs();
        checks++; if (tcr_o !== 32'hB) begin failures++; $display("FAIL defer_viol got=%h exp=%h", tcr_o, 32'hB); end
        checks++; if (viol_cnt_o !== 2'd3) begin failures++; $display("FAIL cnt_sat got=%0d exp=3", viol_cnt_o); end
        ack_and_drain();
        checks++; if (tcr_o !== 32'hC) begin failures++; $display("FAIL defer_viol_apply got=%h exp=%h", tcr_o, 32'hC); end
        raise_s1_viol(32'h0000_0304, 32'h0000_0013);
        checks++; if (viol_cnt_o !== 2'd3) begin failures++; $display("FAIL cnt_sat2 got=%0d exp=3", viol_cnt_o); end
        ack_and_drain();
        clr_cnt_i = 1'b1;
        raise_s1_viol(32'h0000_0308, 32'h0000_0013);
        checks++; if (viol_cnt_o !== 2'd1) begin failures++; $display("FAIL clr_with_viol got=%0d exp=1", viol_cnt_o); end
        ack_and_drain();
        clr_cnt_i = 1'b1;
        step();
        clr_cnt_i = 1'b0;
        checks++; if (viol_cnt_o !== 2'd0) begin failures++; $display("FAIL clr_alone got=%0d exp=0", viol_cnt_o); end
    endtask

    task automatic test_back_to_back();
        raise_s1_viol(32'h0000_0400, 32'h0000_0013);
        ack_and_drain();
        // violation in the very first IDLE cycle after a drain
        ex_valid_i = 1'b1; chk_s2_i = 1'b1; tag_s2_i = 1'b1; ex_pc_i = 32'h0000_0404;
        #1;
        checks++; if (kill_wb_o !== 1'b1) begin failures++; $display("FAIL b2b_kill got=%b exp=1", kill_wb_o); end
        step();
        idle_inputs();
        checks++; if (trap_cause_o !== 4'b0010 || fault_pc_o !== 32'h404) begin failures++; $display("FAIL b2b_ctx got=%b/%h exp=0010/404", trap_cause_o, fault_pc_o); end
        checks++; if (viol_cnt_o !== 2'd2) begin failures++; $display("FAIL b2b_cnt got=%0d exp=2", viol_cnt_o); end
        ack_and_drain();
    endtask

    task automatic test_reset_in_req();
        raise_s1_viol(32'h0000_0500, 32'h0000_0013);
        tcr_wr_i = 1'b1; tcr_wdata_i = 32'h0000_00DD;
        step();
        tcr_wr_i = 1'b0;
        checks++; if (trap_req_o !== 1'b1) begin failures++; $display("FAIL prereset_req got=%b exp=1", trap_req_o); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (trap_req_o !== 1'b0 || halt_ex_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b%b exp=00", trap_req_o, halt_ex_o); end
        checks++; if (tcr_o !== 32'h0) begin failures++; $display("FAIL rst_tcr got=%h exp=0", tcr_o); end
        checks++; if (viol_cnt_o !== 2'd0 || trap_cause_o !== 4'b0000) begin failures++; $display("FAIL rst_cnt_cause got=%0d/%b exp=0/0000", viol_cnt_o, trap_cause_o); end
        // the discarded pending write must not reappear after a later trap
        raise_s1_viol(32'h0000_0600, 32'h0000_0013);
        ack_and_drain();
        checks++; if (tcr_o !== 32'h0) begin failures++; $display("FAIL pend_discard got=%h exp=0", tcr_o); end
    endtask

    initial begin
        test_reset();
        test_tcr_write();
        test_violation();
        test_cause_mask();
        test_deferred_tcr();
        test_saturation();
        test_back_to_back();
        test_reset_in_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
